// File: rtl/q2_plus_alu_pkg.sv
// q2_plus_alu_pkg: shared definitions for the q2_plus compute-stage ALU.
//   DEF_WIDTH        default operand/result width
//   OPC_ADD..OPC_ASR 3-bit operation codes driven on q2_plus_alu.opc
package q2_plus_alu_pkg;

   localparam int unsigned DEF_WIDTH = 16;

   localparam logic [2:0] OPC_ADD = 3'b000;
   localparam logic [2:0] OPC_SUB = 3'b001;
   localparam logic [2:0] OPC_AND = 3'b010;
   localparam logic [2:0] OPC_OR  = 3'b011;
   localparam logic [2:0] OPC_NOT = 3'b100;
   localparam logic [2:0] OPC_XOR = 3'b101;
   localparam logic [2:0] OPC_SHL = 3'b110;
   localparam logic [2:0] OPC_ASR = 3'b111;

endpackage

// File: rtl/q2_plus_addsub.sv
// q2_plus_addsub: WIDTH-bit ripple adder shared by ADD and SUB.
//   a, b   in   WIDTH  operands
//   cin    in   1      carry-in (ADD) / borrow-in (SUB)
//   sub    in   1      1: sum = a + ~b + ~cin (i.e. a - b - cin)
//   sum    out  WIDTH  result modulo 2^WIDTH
//   carry  out  1      carry out of the MSB (inverse of borrow when sub=1)
//   ovf    out  1      signed overflow
module q2_plus_addsub #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   always_comb begin
      logic [WIDTH-1:0] bb;
      logic [WIDTH:0]   c;
      bb   = sub ? ~b : b;
      c    = '0;
      c[0] = sub ? ~cin : cin;
      sum  = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         sum[i]   = a[i] ^ bb[i] ^ c[i];
         c[i+1]   = (a[i] & bb[i]) | (c[i] & (a[i] ^ bb[i]));
      end
      carry = c[WIDTH];
      // Signed overflow: carry into the sign bit differs from carry out of it.
      ovf   = c[WIDTH] ^ c[WIDTH-1];
   end

endmodule

// File: rtl/q2_plus_alu.sv
// q2_plus_alu: 16-bit, 8-function ALU with registered result and flags.
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   opc    in   3      operation select (OPC_* in q2_plus_alu_pkg)
//   ina    in   WIDTH  operand A
//   inb    in   WIDTH  operand B
//   inc    in   1      carry/borrow/shift-in bit
//   w      out  WIDTH  registered result (one-cycle latency)
//   zer    out  1      registered, 1 when w == 0
//   neg    out  1      registered, w[WIDTH-1]
//   cout   out  1      carry/borrow/shifted-out bit (Q2_PLUS_ALU_COUT_EN only)
//   ovf    out  1      signed overflow for ADD/SUB (Q2_PLUS_ALU_COUT_EN only)
// Macro Q2_PLUS_ALU_COUT_EN adds the cout/ovf ports.
module q2_plus_alu
   import q2_plus_alu_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       opc,
   input  logic [WIDTH-1:0] ina,
   input  logic [WIDTH-1:0] inb,
   input  logic             inc,
   output logic [WIDTH-1:0] w,
   output logic             zer,
   output logic             neg
`ifdef Q2_PLUS_ALU_COUT_EN
   ,
   output logic             cout,
   output logic             ovf
`endif
);

   logic [WIDTH-1:0] as_sum;
   logic             as_carry;
   logic             as_ovf;
   logic [WIDTH-1:0] w_next;

   q2_plus_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a     (ina),
      .b     (inb),
      .cin   (inc),
      .sub   (opc == OPC_SUB),
      .sum   (as_sum),
      .carry (as_carry),
      .ovf   (as_ovf)
   );

   always_comb begin
      w_next = '0;
      case (opc)
         OPC_ADD, OPC_SUB: w_next = as_sum;
         OPC_AND:          w_next = ina & inb;
         OPC_OR:           w_next = ina | inb;
         OPC_NOT:          w_next = ~ina;
         OPC_XOR:          w_next = ina ^ inb;
         OPC_SHL:          w_next = {ina[WIDTH-2:0], inc};
         OPC_ASR:          w_next = {ina[WIDTH-1], ina[WIDTH-1:1]};
         default:          w_next = '0;
      endcase
   end

   // Flags are computed from the same value loaded into w, so they can never lag it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w   <= '0;
         zer <= 1'b1;
         neg <= 1'b0;
      end else begin
         w   <= w_next;
         zer <= ~|w_next;
         neg <= w_next[WIDTH-1];
      end
   end

`ifdef Q2_PLUS_ALU_COUT_EN
   logic cout_next;
   logic ovf_next;

   always_comb begin
      cout_next = 1'b0;
      ovf_next  = 1'b0;
      case (opc)
         OPC_ADD: begin
            cout_next = as_carry;
            ovf_next  = as_ovf;
         end
         // Adder carry-out of a + ~b + ~cin is the inverse of the borrow.
         OPC_SUB: begin
            cout_next = ~as_carry;
            ovf_next  = as_ovf;
         end
         OPC_SHL: cout_next = ina[WIDTH-1];
         OPC_ASR: cout_next = ina[0];
         default: cout_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         cout <= cout_next;
         ovf  <= ovf_next;
      end
   end
`else
   logic unused_flags;
   assign unused_flags = as_carry ^ as_ovf;
`endif

endmodule

// File: tb/tb_q2_plus_alu.sv
// tb_q2_plus_alu: scoreboard bench for q2_plus_alu. The driver applies one
// vector per cycle and queues the expected registered response; the monitor
// pops one entry one step after each rising edge and compares.
module tb_q2_plus_alu;

   typedef struct packed {
      logic [15:0] w;
      logic        zer;
      logic        neg;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  opc = 3'b000;
   logic [15:0] ina = '0;
   logic [15:0] inb = '0;
   logic        inc = 1'b0;
   logic [15:0] w;
   logic        zer;
   logic        neg;
`ifdef Q2_PLUS_ALU_COUT_EN
   logic        cout;
   logic        ovf;
`endif

   exp_t  sb[$];
   string sb_name[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   q2_plus_alu #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .opc   (opc),
      .ina   (ina),
      .inb   (inb),
      .inc   (inc),
      .w     (w),
      .zer   (zer),
      .neg   (neg)
`ifdef Q2_PLUS_ALU_COUT_EN
      ,
      .cout  (cout),
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(logic [15:0] ew, logic ez, logic en, logic ec, logic eo);
      exp_t e;
      e.w = ew; e.zer = ez; e.neg = en; e.cout = ec; e.ovf = eo;
      return e;
   endfunction

   // Golden model from integer arithmetic.
   function automatic exp_t model(logic [2:0] op, logic [15:0] a, logic [15:0] b, logic ci);
      exp_t e;
      int   sr;
      logic [16:0] t;
      e = '0;
      case (op)
         3'd0: begin
            t = {1'b0, a} + {1'b0, b} + {16'd0, ci};
            e.w = t[15:0]; e.cout = t[16];
            sr = int'($signed(a)) + int'($signed(b)) + int'(ci);
            e.ovf = (sr > 32767) || (sr < -32768);
         end
         3'd1: begin
            t = {1'b0, a} - {1'b0, b} - {16'd0, ci};
            e.w = t[15:0]; e.cout = t[16];
            sr = int'($signed(a)) - int'($signed(b)) - int'(ci);
            e.ovf = (sr > 32767) || (sr < -32768);
         end
         3'd2: e.w = a & b;
         3'd3: e.w = a | b;
         3'd4: e.w = ~a;
         3'd5: e.w = a ^ b;
         3'd6: begin e.w = (a << 1) | {15'd0, ci}; e.cout = a[15]; end
         default: begin e.w = (a >> 1) | (a & 16'h8000); e.cout = a[0]; end
      endcase
      e.zer = (e.w == 16'h0000);
      e.neg = e.w[15];
      return e;
   endfunction

   task automatic drive(input logic rst, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic ci, input exp_t e, input string nm);
      @(negedge clk);
      rst_n = rst; opc = op; ina = a; inb = b; inc = ci;
      sb.push_back(e);
      sb_name.push_back(nm);
   endtask

   task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", nm, act, req);
      end
   endtask

   // Monitor: DUT presents a new result after every rising edge.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e  = sb.pop_front();
            nm = sb_name.pop_front();
            cmp({nm, ".w"},   w,          e.w);
            cmp({nm, ".zer"}, {15'd0, zer}, {15'd0, e.zer});
            cmp({nm, ".neg"}, {15'd0, neg}, {15'd0, e.neg});
`ifdef Q2_PLUS_ALU_COUT_EN
            cmp({nm, ".cout"}, {15'd0, cout}, {15'd0, e.cout});
            cmp({nm, ".ovf"},  {15'd0, ovf},  {15'd0, e.ovf});
`endif
         end
      end
   end

   initial begin
      logic [15:0] ra, rb;
      logic        rc;
      int          wait_cnt;
      repeat (3) @(posedge clk);

      // Reset discards inputs, then the same inputs register.
      drive(1'b0, 3'b000, 16'h1234, 16'h1111, 1'b0, mk(16'h0000, 1, 0, 0, 0), "reset");
      drive(1'b1, 3'b000, 16'h1234, 16'h1111, 1'b0, mk(16'h2345, 0, 0, 0, 0), "add_after_reset");
      drive(1'b1, 3'b000, 16'hFFFF, 16'h0000, 1'b1, mk(16'h0000, 1, 0, 1, 0), "add_wrap");
      drive(1'b1, 3'b001, 16'h0005, 16'h0007, 1'b0, mk(16'hFFFE, 0, 1, 1, 0), "sub_neg");
      drive(1'b1, 3'b001, 16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 0, 0, 0, 1), "sub_ovf");
      drive(1'b1, 3'b001, 16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 0, 1, 1, 0), "sub_wrap");
      drive(1'b1, 3'b001, 16'h0009, 16'h0003, 1'b1, mk(16'h0005, 0, 0, 0, 0), "sub_borrow_in");
      drive(1'b1, 3'b010, 16'hF0F0, 16'h0FF0, 1'b1, mk(16'h00F0, 0, 0, 0, 0), "and");
      drive(1'b1, 3'b011, 16'hF0F0, 16'h0FF0, 1'b1, mk(16'hFFF0, 0, 1, 0, 0), "or");
      drive(1'b1, 3'b101, 16'hF0F0, 16'h0FF0, 1'b1, mk(16'hFF00, 0, 1, 0, 0), "xor");
      drive(1'b1, 3'b100, 16'hF0F0, 16'h0FF0, 1'b1, mk(16'h0F0F, 0, 0, 0, 0), "not");
      drive(1'b1, 3'b110, 16'h8001, 16'h5555, 1'b1, mk(16'h0003, 0, 0, 1, 0), "shl");
      drive(1'b1, 3'b111, 16'h8001, 16'h5555, 1'b1, mk(16'hC000, 0, 1, 1, 0), "asr");
      drive(1'b1, 3'b111, 16'h0001, 16'h0000, 1'b0, mk(16'h0000, 1, 0, 1, 0), "asr_zero");
      drive(1'b0, 3'b110, 16'hFFFF, 16'hFFFF, 1'b1, mk(16'h0000, 1, 0, 0, 0), "reset_mid");

      for (int i = 0; i < 24; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         drive(1'b1, 3'(i % 8), ra, rb, rc, model(3'(i % 8), ra, rb, rc), $sformatf("rand%0d", i));
      end

      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      #2;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
